// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory arbiter.
//  arb_state_e : arbitration FSM states
//  req_idx_t   : requester index, wide enough for the largest legal NUM_REQ (4)
//  last_rst()  : reset value of the round-robin pointer, so requester 0 wins first
package dmem_arb_pkg;

  // Fixed at the width needed for NUM_REQ=4 so one type serves every legal build.
  localparam int unsigned REQ_IDX_W = 2;

  typedef logic [REQ_IDX_W-1:0] req_idx_t;

  typedef enum logic {
    ARB_FREE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

  localparam int unsigned DEF_NUM_REQ  = 2;
  localparam req_idx_t    LAST_RST_DEF = req_idx_t'(DEF_NUM_REQ - 1);

  // Pointer parked on the highest index so the scan starts at requester 0.
  function automatic req_idx_t last_rst(input int unsigned n);
    return req_idx_t'(n - 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Combinational round-robin picker.
//  req  : request vector
//  last : index granted most recently; the scan starts at last+1
//  mask : only requesters with mask=1 may win
//  gnt  : one-hot grant (zero if nobody eligible)
//  idx  : index of the granted requester (0 if none)
module rr_pick
  import dmem_arb_pkg::*;
#(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0] req,
  input  req_idx_t     last,
  input  logic [N-1:0] mask,
  output logic [N-1:0] gnt,
  output req_idx_t     idx
);

  logic [N-1:0] elig;
  logic         found;

  assign elig = req & mask;

  // Scan last+1, last+2, ... modulo N; first eligible requester wins.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!found && elig[j] && (j == (32'(last) + i) % N)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          idx    = req_idx_t'(j);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing a single-port data memory (async read, sync write)
// between NUM_REQ requesters, with a bounded lock for read-modify-write.
//  clk, rst             : clock, synchronous active-high reset
//  req/lock/wen         : per-requester request, keep-ownership, write-enable
//  addr/wdata           : packed per-requester address / write data
//  gnt                  : one-hot grant, combinational in the request cycle
//  rvalid/rdata         : registered read return, one cycle after a read grant
//  mem_wen/addr/data_in : drive the data memory
//  mem_data_out         : async read data from the data memory
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int unsigned DATA_PATH_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH      = 8,
  parameter int unsigned NUM_REQ         = 2,
  parameter int unsigned LOCK_MAX        = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req,
  input  logic [NUM_REQ-1:0]              lock,
  input  logic [NUM_REQ-1:0]              wen,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr,
  input  logic [NUM_REQ*DATA_PATH_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]              gnt,
  output logic [NUM_REQ-1:0]              rvalid,
  output logic [DATA_PATH_WIDTH-1:0]      rdata,
  output logic                            mem_wen,
  output logic [ADDR_WIDTH-1:0]           mem_addr,
  output logic [DATA_PATH_WIDTH-1:0]      mem_data_in,
  input  logic [DATA_PATH_WIDTH-1:0]      mem_data_out
);

  localparam int unsigned AW    = ADDR_WIDTH;
  localparam int unsigned DW    = DATA_PATH_WIDTH;
  localparam int unsigned CNT_W = $clog2(LOCK_MAX + 1);
  localparam req_idx_t    LAST_RST = last_rst(NUM_REQ);

  arb_state_e         state;
  req_idx_t           owner;
  req_idx_t           last;
  logic [CNT_W-1:0]   lock_cnt;

  logic               locked_eff;
  logic [NUM_REQ-1:0] mask;
  logic               own_lock;
  logic [NUM_REQ-1:0] pick_gnt;
  req_idx_t           pick_idx;
  logic               win;
  logic               wen_g;
  logic               lock_g;

  // A lock that has reached LOCK_MAX is released before arbitration this cycle.
  assign locked_eff = (state == ARB_LOCKED) && (lock_cnt < CNT_W'(LOCK_MAX));

  // Eligibility mask and owner's lock bit.
  always_comb begin
    mask     = '1;
    own_lock = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (locked_eff) mask[j] = (owner == req_idx_t'(j));
      if (owner == req_idx_t'(j)) own_lock = lock[j];
    end
  end

  rr_pick #(.N(NUM_REQ)) u_pick (
    .req  (req),
    .last (last),
    .mask (mask),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  // No access is presented while reset is asserted.
  assign gnt = rst ? '0 : pick_gnt;
  assign win = |gnt;

  // Winner's fields onto the memory port; zeros when idle.
  always_comb begin
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    wen_g       = 1'b0;
    lock_g      = 1'b0;
    for (int unsigned j = 0; j < NUM_REQ; j++) begin
      if (gnt[j]) begin
        mem_wen     = wen[j];
        mem_addr    = addr[j*AW +: AW];
        mem_data_in = wdata[j*DW +: DW];
        wen_g       = wen[j];
        lock_g      = lock[j];
      end
    end
  end

  // FSM, pointer, lock counter and read return.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ARB_FREE;
      owner    <= '0;
      last     <= LAST_RST;
      lock_cnt <= '0;
      rdata    <= '0;
      rvalid   <= '0;
    end else begin
      rvalid <= '0;
      if (win) begin
        last <= pick_idx;
        if (!wen_g) begin
          rdata  <= mem_data_out;
          rvalid <= gnt;
        end
        if (lock_g) begin
          if (locked_eff) begin
            lock_cnt <= lock_cnt + CNT_W'(1);
          end else begin
            state    <= ARB_LOCKED;
            owner    <= pick_idx;
            lock_cnt <= CNT_W'(1);
          end
        end else begin
          state    <= ARB_FREE;
          lock_cnt <= '0;
        end
      end else if (locked_eff) begin
        // Owner idle: holding the lock still consumes budget; dropping it frees.
        if (own_lock) begin
          lock_cnt <= lock_cnt + CNT_W'(1);
        end else begin
          state    <= ARB_FREE;
          lock_cnt <= '0;
        end
      end else if (state == ARB_LOCKED) begin
        state    <= ARB_FREE;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a behavioural data memory.
module tb_dmem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] req, lock, wen;
  logic [7:0] a0, a1, d0, d1;
  logic [1:0] gnt, rvalid;
  logic [7:0] rdata;
  logic       mem_wen;
  logic [7:0] mem_addr, mem_data_in, mem_data_out;

  logic [7:0] mem [256];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .DATA_PATH_WIDTH(8), .ADDR_WIDTH(8), .NUM_REQ(2), .LOCK_MAX(8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .lock         (lock),
    .wen          (wen),
    .addr         ({a1, a0}),
    .wdata        ({d1, d0}),
    .gnt          (gnt),
    .rvalid       (rvalid),
    .rdata        (rdata),
    .mem_wen      (mem_wen),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Data memory: async read, sync write, preset contents while in reset.
  assign mem_data_out = mem[mem_addr];
  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 256; k++) mem[k] <= 8'h00;
      mem[8'h01] <= 8'h11;
      mem[8'h02] <= 8'h22;
      mem[8'h20] <= 8'h07;
    end else if (mem_wen) begin
      mem[mem_addr] <= mem_data_in;
    end
  end

  typedef struct {
    logic [1:0] req, lock, wen;
    logic [7:0] a0, a1, d0, d1;
    logic [1:0] gnt;
    logic       mwen;
    logic [7:0] maddr;
    logic [1:0] rv;
    logic [7:0] rd;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic [1:0] rq, logic [1:0] lk, logic [1:0] we,
                              logic [7:0] x0, logic [7:0] x1, logic [7:0] y0, logic [7:0] y1,
                              logic [1:0] g, logic mw, logic [7:0] ma, logic [1:0] rv, logic [7:0] rd);
    vec_t v;
    v.req = rq; v.lock = lk; v.wen = we;
    v.a0 = x0; v.a1 = x1; v.d0 = y0; v.d1 = y1;
    v.gnt = g; v.mwen = mw; v.maddr = ma; v.rv = rv; v.rd = rd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] we,
                       input logic [7:0] x0, input logic [7:0] x1,
                       input logic [7:0] y0, input logic [7:0] y1);
    req = rq; lock = lk; wen = we; a0 = x0; a1 = x1; d0 = y0; d1 = y1;
  endtask

  initial begin
    logic [7:0] exp_din;
    rst = 1'b1;
    drive(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00);

    // Table: each row is one cycle; rv/rd are the registered results of the previous row.
    // Test 1: write then read back
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 8'h10, 8'h00, 8'hA5, 8'h00, 2'b01, 1'b1, 8'h10, 2'b00, 8'h00));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h10, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 8'h10, 2'b00, 8'h00));
    // Park pointer on 1, then test 2: alternating reads
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h02, 8'h00, 8'h00, 2'b10, 1'b0, 8'h02, 2'b01, 8'hA5));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01, 1'b0, 8'h01, 2'b10, 8'h22));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 1'b0, 8'h02, 2'b01, 8'h11));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b01, 1'b0, 8'h01, 2'b10, 8'h22));
    tbl.push_back(mk(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00, 2'b10, 1'b0, 8'h02, 2'b01, 8'h11));
    // Park pointer on 0, then test 3: locked RMW by req1 with req0 waiting
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h01, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 8'h01, 2'b10, 8'h22));
    tbl.push_back(mk(2'b11, 2'b10, 2'b00, 8'h01, 8'h20, 8'h00, 8'h00, 2'b10, 1'b0, 8'h20, 2'b01, 8'h11));
    tbl.push_back(mk(2'b11, 2'b00, 2'b10, 8'h01, 8'h20, 8'h00, 8'h08, 2'b10, 1'b1, 8'h20, 2'b10, 8'h07));
    tbl.push_back(mk(2'b01, 2'b00, 2'b00, 8'h20, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 8'h20, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 2'b01, 8'h08));
    // Test 4: lock held to LOCK_MAX, 8 grants to req1 then req0
    tbl.push_back(mk(2'b10, 2'b10, 2'b00, 8'h00, 8'h30, 8'h00, 8'h00, 2'b10, 1'b0, 8'h30, 2'b00, 8'h00));
    for (int i = 0; i < 7; i++)
      tbl.push_back(mk(2'b11, 2'b10, 2'b00, 8'h31, 8'h30, 8'h00, 8'h00, 2'b10, 1'b0, 8'h30, 2'b10, 8'h00));
    tbl.push_back(mk(2'b11, 2'b10, 2'b00, 8'h31, 8'h30, 8'h00, 8'h00, 2'b01, 1'b0, 8'h31, 2'b10, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 2'b01, 8'h00));
    // Locked owner idle with lock=1 blocks others; dropping lock frees without access
    tbl.push_back(mk(2'b01, 2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 2'b01, 1'b0, 8'h40, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b01, 2'b00, 8'h40, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 2'b01, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h40, 8'h50, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 2'b00, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h50, 8'h00, 8'h00, 2'b10, 1'b0, 8'h50, 2'b00, 8'h00));
    // Test 6: write by req0, read by req1 on the next cycle
    tbl.push_back(mk(2'b01, 2'b00, 2'b01, 8'h55, 8'h00, 8'h3C, 8'h00, 2'b01, 1'b1, 8'h55, 2'b10, 8'h00));
    tbl.push_back(mk(2'b10, 2'b00, 2'b00, 8'h00, 8'h55, 8'h00, 8'h00, 2'b10, 1'b0, 8'h55, 2'b00, 8'h00));
    tbl.push_back(mk(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00, 2'b10, 8'h3C));

    // Reset state, with a request presented during reset
    @(negedge clk);
    #2;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_mem_wen", 32'(mem_wen), 32'h0);
    check("rst_rvalid", 32'(rvalid), 32'h0);
    check("rst_rdata", 32'(rdata), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].req, tbl[i].lock, tbl[i].wen, tbl[i].a0, tbl[i].a1, tbl[i].d0, tbl[i].d1);
      #2;
      exp_din = tbl[i].gnt[0] ? tbl[i].d0 : (tbl[i].gnt[1] ? tbl[i].d1 : 8'h00);
      check($sformatf("v%0d_gnt", i), 32'(gnt), 32'(tbl[i].gnt));
      check($sformatf("v%0d_mem_wen", i), 32'(mem_wen), 32'(tbl[i].mwen));
      check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(tbl[i].maddr));
      check($sformatf("v%0d_mem_data_in", i), 32'(mem_data_in), 32'(exp_din));
      check($sformatf("v%0d_rvalid", i), 32'(rvalid), 32'(tbl[i].rv));
      if (tbl[i].rv != 2'b00)
        check($sformatf("v%0d_rdata", i), 32'(rdata), 32'(tbl[i].rd));
    end

    // Test 5: reset the cycle after a locked read grant by req1
    @(negedge clk);
    drive(2'b10, 2'b10, 2'b00, 8'h00, 8'h02, 8'h00, 8'h00);
    #2;
    check("t5_pre_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    rst = 1'b1;
    drive(2'b11, 2'b00, 2'b01, 8'h01, 8'h02, 8'hFF, 8'hFF);
    #2;
    check("t5_rst_gnt", 32'(gnt), 32'h0);
    check("t5_rst_mem_wen", 32'(mem_wen), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(2'b11, 2'b00, 2'b00, 8'h01, 8'h02, 8'h00, 8'h00);
    #2;
    check("t5_post_rvalid", 32'(rvalid), 32'h0);
    check("t5_post_rdata", 32'(rdata), 32'h0);
    check("t5_post_gnt", 32'(gnt), 32'h1);
    @(negedge clk);
    drive(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 8'h00, 8'h00);
    #2;
    check("t5_read_rvalid", 32'(rvalid), 32'h1);
    check("t5_read_rdata", 32'(rdata), 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
